// File: rtl/transform_seq_ctrl.sv
// transform_seq_ctrl
// Sequencer for the residual inverse-transform datapath (DHT / IQ / IDCT / DC regs).
// For each residual block it walks a phase route chosen by the block type, raises the
// datapath write and mode strobes, and reports completion through a valid/ready handshake.
//
// Handshake: valid is high while the block result sits in DONE. It is consumed on a cycle
// with ena & out_ready. On that same cycle a new start is accepted, so back-to-back blocks
// lose no cycle. A start in any other busy cycle is dropped and flagged on start_err.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 global advance enable; low freezes state and zeroes all strobes
//   start               block request (accepted in IDLE or on the DONE handshake cycle)
//   blk_type            0 LUMA_DC, 1 CHROMA_DC, 2 AC4x4, 3 AC8x8, 4+ SKIP
//   total_coeff         nonzero coefficient count of the block
//   comp, blk_idx       component (0 Y, 1 Cb, 2 Cr) and 4x4 block index
//   out_ready           downstream accepts completion
//   busy, valid         not IDLE / in DONE
//   dht_wr .. all0_wr   datapath write strobes
//   col_mode, out_sel   second-pass select, last-cycle-of-pass select
//   dc_rd_idx           DC register read index latched for the current block
//   state_o             FSM state, exposed for debug
//   start_err           start seen while busy and not acceptable
module transform_seq_ctrl #(
    parameter int DHT_CLKS   = 6,
    parameter int DHT2_CLKS  = 2,
    parameter int IQ_CLKS    = 3,
    parameter int IDCT_CLKS  = 6,
    parameter int IDCT8_CLKS = 10,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [2:0] blk_type,
    input  logic [6:0] total_coeff,
    input  logic [1:0] comp,
    input  logic [3:0] blk_idx,
    input  logic       out_ready,
    output logic       busy,
    output logic       valid,
    output logic       dht_wr,
    output logic       iq_wr,
    output logic       idct_wr,
    output logic       dc_regs_wr,
    output logic       all0_wr,
    output logic       col_mode,
    output logic       out_sel,
    output logic [3:0] dc_rd_idx,
    output logic [2:0] state_o,
    output logic       start_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DHT  = 3'd1;
    localparam logic [2:0] S_IQ   = 3'd2;
    localparam logic [2:0] S_IDCT = 3'd3;
    localparam logic [2:0] S_ZERO = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [2:0] T_LUMA_DC   = 3'd0;
    localparam logic [2:0] T_CHROMA_DC = 3'd1;
    localparam logic [2:0] T_AC4       = 3'd2;
    localparam logic [2:0] T_AC8       = 3'd3;
    localparam logic [2:0] T_SKIP      = 3'd4;

    localparam logic [CNT_W-1:0] DHT_LAST   = CNT_W'(DHT_CLKS - 1);
    localparam logic [CNT_W-1:0] DHT_HALF   = CNT_W'(DHT_CLKS / 2);
    localparam logic [CNT_W-1:0] DHT_HM1    = CNT_W'(DHT_CLKS / 2 - 1);
    localparam logic [CNT_W-1:0] DHT2_LAST  = CNT_W'(DHT2_CLKS - 1);
    localparam logic [CNT_W-1:0] IQ_LAST    = CNT_W'(IQ_CLKS - 1);
    localparam logic [CNT_W-1:0] IDCT4_LAST = CNT_W'(IDCT_CLKS - 1);
    localparam logic [CNT_W-1:0] IDCT4_HALF = CNT_W'(IDCT_CLKS / 2);
    localparam logic [CNT_W-1:0] IDCT4_HM1  = CNT_W'(IDCT_CLKS / 2 - 1);
    localparam logic [CNT_W-1:0] IDCT8_LAST = CNT_W'(IDCT8_CLKS - 1);
    localparam logic [CNT_W-1:0] IDCT8_HALF = CNT_W'(IDCT8_CLKS / 2);
    localparam logic [CNT_W-1:0] IDCT8_HM1  = CNT_W'(IDCT8_CLKS / 2 - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       type_q, type_d;
    logic [3:0]       dc_idx_q, dc_idx_d;

    // The route is fully determined at accept time, so only the (normalised) block type
    // needs to be kept; the coefficient count only chooses between IQ and ZERO up front.
    logic       accept;
    logic [2:0] in_type;
    logic [2:0] route_first;
    logic [3:0] in_dc_idx;

    logic             is_luma, is_chroma, is_dc, is_ac8;
    logic [CNT_W-1:0] dht_last, idct_last, idct_half, idct_hm1;
    logic             in_dht, in_iq, in_idct;

    assign accept  = ena & start & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign in_type = (blk_type > T_SKIP) ? T_SKIP : blk_type;

    always_comb begin
        route_first = S_ZERO;
        case (in_type)
            T_LUMA_DC, T_CHROMA_DC: route_first = S_DHT;
            T_AC4, T_AC8:           route_first = (total_coeff != 7'd0) ? S_IQ : S_ZERO;
            default:                route_first = S_ZERO;
        endcase
    end

    // Only 4x4 AC blocks read a DC register; chroma maps onto the 2x2 DC arrays.
    always_comb begin
        in_dc_idx = 4'd0;
        if (in_type == T_AC4) begin
            case (comp)
                2'd0:    in_dc_idx = blk_idx;
                2'd1:    in_dc_idx = {2'b00, blk_idx[1:0]};
                2'd2:    in_dc_idx = {2'b01, blk_idx[1:0]};
                default: in_dc_idx = 4'd0;
            endcase
        end
    end

    assign is_luma   = (type_q == T_LUMA_DC);
    assign is_chroma = (type_q == T_CHROMA_DC);
    assign is_dc     = is_luma | is_chroma;
    assign is_ac8    = (type_q == T_AC8);
    assign dht_last  = is_luma ? DHT_LAST : DHT2_LAST;
    assign idct_last = is_ac8 ? IDCT8_LAST : IDCT4_LAST;
    assign idct_half = is_ac8 ? IDCT8_HALF : IDCT4_HALF;
    assign idct_hm1  = is_ac8 ? IDCT8_HM1 : IDCT4_HM1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        type_d   = type_q;
        dc_idx_d = dc_idx_q;
        if (ena) begin
            case (state_q)
                S_IDLE: ;
                S_DHT: begin
                    if (cnt_q == dht_last) begin
                        state_d = S_IQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_IQ: begin
                    if (cnt_q == IQ_LAST) begin
                        state_d = is_dc ? S_DONE : S_IDCT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_IDCT: begin
                    if (cnt_q == idct_last) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_ZERO: begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
            // Accept overrides the DONE->IDLE exit so the next route starts immediately.
            if (accept) begin
                state_d  = route_first;
                cnt_d    = '0;
                type_d   = in_type;
                dc_idx_d = in_dc_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            type_q   <= 3'd0;
            dc_idx_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            dc_idx_q <= dc_idx_d;
        end
    end

    assign in_dht  = ena & (state_q == S_DHT);
    assign in_iq   = ena & (state_q == S_IQ);
    assign in_idct = ena & (state_q == S_IDCT);

    assign busy       = (state_q != S_IDLE);
    assign valid      = (state_q == S_DONE);
    assign state_o    = state_q;
    assign dc_rd_idx  = dc_idx_q;
    assign dht_wr     = in_dht & ((cnt_q == '0) | (is_luma & (cnt_q == DHT_HALF)));
    assign iq_wr      = in_iq & (cnt_q == '0);
    assign dc_regs_wr = in_iq & is_dc & (cnt_q == IQ_LAST);
    assign idct_wr    = in_idct & ((cnt_q == '0) | (cnt_q == idct_half));
    assign all0_wr    = ena & (state_q == S_ZERO);
    // Chroma DHT is a single pass: no column mode, one result select at its end.
    assign col_mode   = (in_dht & is_luma & (cnt_q >= DHT_HALF)) |
                        (in_idct & (cnt_q >= idct_half));
    assign out_sel    = (in_dht & is_luma & ((cnt_q == DHT_HM1) | (cnt_q == DHT_LAST))) |
                        (in_dht & is_chroma & (cnt_q == DHT2_LAST)) |
                        (in_idct & ((cnt_q == idct_hm1) | (cnt_q == idct_last)));
    assign start_err  = ena & start & (state_q != S_IDLE) & ~((state_q == S_DONE) & out_ready);

endmodule
